// File: rtl/regfile_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter_if
//   Bundles the two writeback request channels, the clear control and the
//   registered register-file write port of regfile_wr_arbiter.
//
//   master modport : requester / environment side (drives requests, clr_start)
//   slave modport  : arbiter side (drives readies, busy and the rf_* port)
//
//   req0_*    : ALU writeback channel       (valid/ready, addr, data)
//   req1_*    : load/store writeback channel (valid/ready, addr, data)
//   clr_start : single-cycle pulse requesting a clear of r1..r(NREG-1)
//   busy      : clear sequence in progress
//   rf_we/rf_waddr/rf_wdata : registered register-file write port
//   rf_src    : which channel produced the current rf_we (0 during clear)
// ---------------------------------------------------------------------------
interface regfile_wr_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;

    logic              clr_start;
    logic              busy;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_src;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output clr_start,
        input  req0_ready, req1_ready, busy,
        input  rf_we, rf_waddr, rf_wdata, rf_src
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  clr_start,
        output req0_ready, req1_ready, busy,
        output rf_we, rf_waddr, rf_wdata, rf_src
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
//   Owns the single write port of the register file and shares it between
//   two writers with round-robin arbitration, one write per cycle. After
//   reset (and on clr_start) it zeroes r1..r(NREG-1) in ascending order
//   before accepting requests. Writes to x0 complete their handshake but
//   never assert rf_we.
//
//   clk : clock, all state on rising edge
//   rst : asynchronous, active-high reset
//   bus : regfile_wr_arbiter_if.slave (request channels, clear control,
//         registered rf_we/rf_waddr/rf_wdata/rf_src)
// ---------------------------------------------------------------------------
module regfile_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_arbiter_if.slave  bus
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] FIRST_CNT = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_CNT  = ADDR_W'(NREG - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ptr_q, ptr_d;       // port favoured on a tie
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              rf_src_q, rf_src_d;

    logic              gnt0, gnt1;

    // Grants: only in RUN and never in the cycle a clear is requested, so
    // the clear always wins over pending writes. Addresses play no part.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first;
        // a path that leaves one unassigned would infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == ST_RUN && !bus.clr_start) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = ~ptr_q;
                gnt1 = ptr_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    // Next-state and registered write-port values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rf_src_d   = rf_src_q;

        unique case (state_q)
            ST_CLEAR: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = cnt_q;
                rf_wdata_d = '0;
                rf_src_d   = 1'b0;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_RUN;
                    cnt_d   = FIRST_CNT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (bus.clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = FIRST_CNT;
                end else if (gnt0) begin
                    rf_we_d    = (bus.req0_addr != '0);
                    rf_waddr_d = bus.req0_addr;
                    rf_wdata_d = bus.req0_data;
                    rf_src_d   = 1'b0;
                    ptr_d      = 1'b1;
                end else if (gnt1) begin
                    rf_we_d    = (bus.req1_addr != '0);
                    rf_waddr_d = bus.req1_addr;
                    rf_wdata_d = bus.req1_data;
                    rf_src_d   = 1'b1;
                    ptr_d      = 1'b0;
                end
            end

            default: begin
                state_d = ST_CLEAR;
                cnt_d   = FIRST_CNT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= FIRST_CNT;
            ptr_q      <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rf_src_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_src_q   <= rf_src_d;
        end
    end

    assign bus.busy       = (state_q == ST_CLEAR);
    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.rf_src     = rf_src_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//   Self-checking bench for regfile_wr_arbiter. Requesters are queues of
//   pending writes; the reference model tracks "clear writes remaining",
//   the favoured port and the expected write-port contents, plus a shadow
//   register file compared against one rebuilt from the DUT's writes.
// ---------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk;
    logic rst;

    regfile_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors;
    int checks;

    wr_t q0[$];
    wr_t q1[$];
    logic clr_pulse;

    // Reference model state
    int                m_clear_left;
    int                m_next_clear;
    int                m_favour;
    logic              e_we;
    logic [ADDR_W-1:0] e_waddr;
    logic [DATA_W-1:0] e_wdata;
    logic              e_src;
    logic [DATA_W-1:0] mdl_mem [NREG];
    logic [DATA_W-1:0] dut_mem [NREG];

    // Last observed DUT outputs
    logic              obs_busy, obs_r0, obs_r1, obs_we, obs_src;
    logic [ADDR_W-1:0] obs_waddr;
    logic [DATA_W-1:0] obs_wdata;

    task automatic model_reset();
        m_clear_left = NREG - 1;
        m_next_clear = 1;
        m_favour     = 0;
        e_we         = 1'b0;
        e_waddr      = '0;
        e_wdata      = '0;
        e_src        = 1'b0;
    endtask

    // One clock cycle: drive requests, compare outputs with the model,
    // advance the model, then move to 1 time unit after the next edge.
    task automatic step(input string tag);
        int   g;
        logic v0, v1;
        logic exp_busy;
        wr_t  w0, w1;
        v0 = (q0.size() > 0);
        v1 = (q1.size() > 0);
        w0.addr = ADDR_W'($urandom_range(0, NREG - 1));
        w0.data = $urandom;
        w1.addr = ADDR_W'($urandom_range(0, NREG - 1));
        w1.data = $urandom;
        if (v0) w0 = q0[0];
        if (v1) w1 = q1[0];
        bus.req0_valid = v0;
        bus.req0_addr  = w0.addr;
        bus.req0_data  = w0.data;
        bus.req1_valid = v1;
        bus.req1_addr  = w1.addr;
        bus.req1_data  = w1.data;
        bus.clr_start  = clr_pulse;
        #2;
        exp_busy = (m_clear_left > 0);
        g = -1;
        if (!exp_busy && !clr_pulse) begin
            if (v0 && v1) g = m_favour;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        obs_busy  = bus.busy;
        obs_r0    = bus.req0_ready;
        obs_r1    = bus.req1_ready;
        obs_we    = bus.rf_we;
        obs_waddr = bus.rf_waddr;
        obs_wdata = bus.rf_wdata;
        obs_src   = bus.rf_src;

        checks++;
        if (obs_busy !== exp_busy) begin
            errors++;
            $display("FAIL %s busy: got %0b expected %0b", tag, obs_busy, exp_busy);
        end
        checks++;
        if (obs_r0 !== (g == 0)) begin
            errors++;
            $display("FAIL %s req0_ready: got %0b expected %0b", tag, obs_r0, (g == 0));
        end
        checks++;
        if (obs_r1 !== (g == 1)) begin
            errors++;
            $display("FAIL %s req1_ready: got %0b expected %0b", tag, obs_r1, (g == 1));
        end
        checks++;
        if (obs_we !== e_we) begin
            errors++;
            $display("FAIL %s rf_we: got %0b expected %0b", tag, obs_we, e_we);
        end
        checks++;
        if (obs_waddr !== e_waddr) begin
            errors++;
            $display("FAIL %s rf_waddr: got %0d expected %0d", tag, obs_waddr, e_waddr);
        end
        checks++;
        if (obs_wdata !== e_wdata) begin
            errors++;
            $display("FAIL %s rf_wdata: got %h expected %h", tag, obs_wdata, e_wdata);
        end
        checks++;
        if (obs_src !== e_src) begin
            errors++;
            $display("FAIL %s rf_src: got %0b expected %0b", tag, obs_src, e_src);
        end

        if (obs_we === 1'b1) dut_mem[obs_waddr] = obs_wdata;
        if (e_we) mdl_mem[e_waddr] = e_wdata;

        if (exp_busy) begin
            e_we    = 1'b1;
            e_waddr = ADDR_W'(m_next_clear);
            e_wdata = '0;
            e_src   = 1'b0;
            m_next_clear++;
            m_clear_left--;
        end else if (clr_pulse) begin
            m_clear_left = NREG - 1;
            m_next_clear = 1;
            e_we         = 1'b0;
        end else if (g >= 0) begin
            e_waddr  = (g == 0) ? w0.addr : w1.addr;
            e_wdata  = (g == 0) ? w0.data : w1.data;
            e_we     = (e_waddr != 0);
            e_src    = (g == 1);
            m_favour = 1 - g;
        end else begin
            e_we = 1'b0;
        end

        if (g == 0) void'(q0.pop_front());
        if (g == 1) void'(q1.pop_front());
        clr_pulse = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset from mid-cycle: outputs must drop without an edge.
    task automatic apply_reset(input string tag);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== '0 || bus.rf_wdata !== '0 || bus.rf_src !== 1'b0) begin
            errors++;
            $display("FAIL %s reset outputs: got we=%0b waddr=%0d wdata=%h src=%0b expected all zero",
                     tag, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.rf_src);
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s reset status: got busy=%0b r0=%0b r1=%0b expected 1 0 0",
                     tag, bus.busy, bus.req0_ready, bus.req1_ready);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(tag);
            if (obs_busy === 1'b0) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s wait_idle: busy still %0b after 40 cycles, expected 0", tag, obs_busy);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (q0.size() > 0 || q1.size() > 0); i++) step(tag);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s drain: pending q0=%0d q1=%0d expected 0 0", tag, q0.size(), q1.size());
        end
        step(tag);
    endtask

    task automatic test_reset();
        apply_reset("reset");
        for (int i = 0; i <= 32; i++) begin
            step("reset_clear");
            checks++;
            if (obs_busy !== (i < 31)) begin
                errors++;
                $display("FAIL clear_busy cycle %0d: got %0b expected %0b", i, obs_busy, (i < 31));
            end
            if (i >= 1 && i <= 31) begin
                checks++;
                if (obs_we !== 1'b1 || obs_waddr !== ADDR_W'(i) || obs_wdata !== '0) begin
                    errors++;
                    $display("FAIL clear_write cycle %0d: got we=%0b waddr=%0d wdata=%h expected 1 %0d 0",
                             i, obs_we, obs_waddr, obs_wdata, i);
                end
            end
        end
        step("reset_after");
        checks++;
        if (obs_we !== 1'b0) begin
            errors++;
            $display("FAIL clear_done rf_we: got %0b expected 0", obs_we);
        end
    endtask

    task automatic test_single();
        q0.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
        step("single");
        checks++;
        if (obs_r0 !== 1'b1) begin
            errors++;
            $display("FAIL single req0_ready: got %0b expected 1", obs_r0);
        end
        step("single");
        checks++;
        if (obs_we !== 1'b1 || obs_waddr !== 5'd5 || obs_wdata !== 32'hDEADBEEF || obs_src !== 1'b0) begin
            errors++;
            $display("FAIL single write: got we=%0b waddr=%0d wdata=%h src=%0b expected 1 5 deadbeef 0",
                     obs_we, obs_waddr, obs_wdata, obs_src);
        end
    endtask

    task automatic test_alternate();
        int exp_g [4];
        int exp_a [4];
        int g;
        exp_g = '{0, 1, 0, 1};
        exp_a = '{1, 9, 2, 10};
        apply_reset("alt_reset");
        wait_idle("alt_clear");
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{addr: ADDR_W'(1 + i), data: $urandom});
            q1.push_back('{addr: ADDR_W'(9 + i), data: $urandom});
        end
        for (int i = 0; i < 5; i++) begin
            step("alternate");
            if (i < 4) begin
                g = obs_r0 ? 0 : (obs_r1 ? 1 : -1);
                checks++;
                if (g != exp_g[i]) begin
                    errors++;
                    $display("FAIL alternate grant %0d: got %0d expected %0d", i, g, exp_g[i]);
                end
            end
            if (i >= 1) begin
                checks++;
                if (obs_we !== 1'b1 || obs_waddr !== ADDR_W'(exp_a[i-1])) begin
                    errors++;
                    $display("FAIL alternate waddr %0d: got we=%0b waddr=%0d expected 1 %0d",
                             i - 1, obs_we, obs_waddr, exp_a[i-1]);
                end
            end
        end
        drain("alt_drain");
    endtask

    task automatic test_x0();
        q1.push_back('{addr: 5'd0, data: 32'h1234});
        step("x0");
        checks++;
        if (obs_r1 !== 1'b1) begin
            errors++;
            $display("FAIL x0 req1_ready: got %0b expected 1", obs_r1);
        end
        q0.push_back('{addr: 5'd3, data: $urandom});
        q1.push_back('{addr: 5'd4, data: $urandom});
        step("x0");
        checks++;
        if (obs_we !== 1'b0) begin
            errors++;
            $display("FAIL x0 rf_we: got %0b expected 0", obs_we);
        end
        checks++;
        if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin
            errors++;
            $display("FAIL x0 next grant: got r0=%0b r1=%0b expected 1 0", obs_r0, obs_r1);
        end
        drain("x0_drain");
    endtask

    task automatic test_clear_request();
        int  busy_cycles;
        bit  done;
        q0.push_back('{addr: 5'd7, data: $urandom});
        clr_pulse = 1'b1;
        step("clr_req");
        checks++;
        if (obs_r0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_req req0_ready: got %0b expected 0", obs_r0);
        end
        busy_cycles = 0;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step("clr_run");
            if (obs_busy === 1'b1) busy_cycles++;
            else done = 1;
        end
        checks++;
        if (busy_cycles != NREG - 1) begin
            errors++;
            $display("FAIL clr_req busy cycles: got %0d expected %0d", busy_cycles, NREG - 1);
        end
        checks++;
        if (obs_r0 !== 1'b1) begin
            errors++;
            $display("FAIL clr_req accept when idle: got %0b expected 1", obs_r0);
        end
        step("clr_after");
        checks++;
        if (obs_we !== 1'b1 || obs_waddr !== 5'd7) begin
            errors++;
            $display("FAIL clr_req write: got we=%0b waddr=%0d expected 1 7", obs_we, obs_waddr);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        clr_pulse = 1'b1;
        step("mid_clr");
        n = 0;
        for (int i = 0; i < 40 && n < 10; i++) begin
            step("mid_clr");
            if (obs_we === 1'b1) n++;
        end
        checks++;
        if (n != 10 || obs_waddr !== 5'd10) begin
            errors++;
            $display("FAIL mid_clr tenth write: got count=%0d waddr=%0d expected 10 10", n, obs_waddr);
        end
        apply_reset("mid_clr_reset");
        step("mid_clr_restart");
        step("mid_clr_restart");
        checks++;
        if (obs_we !== 1'b1 || obs_waddr !== 5'd1) begin
            errors++;
            $display("FAIL mid_clr restart: got we=%0b waddr=%0d expected 1 1", obs_we, obs_waddr);
        end
        wait_idle("mid_clr_idle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 3 && $urandom_range(0, 2) != 0)
                q0.push_back('{addr: ADDR_W'($urandom_range(0, NREG - 1)), data: $urandom});
            if (q1.size() < 3 && $urandom_range(0, 2) != 0)
                q1.push_back('{addr: ADDR_W'($urandom_range(0, NREG - 1)), data: $urandom});
            if ($urandom_range(0, 79) == 0) clr_pulse = 1'b1;
            step("random");
        end
        drain("random_drain");
        wait_idle("random_idle");
        for (int a = 0; a < NREG; a++) begin
            checks++;
            if (dut_mem[a] !== mdl_mem[a]) begin
                errors++;
                $display("FAIL random regfile r%0d: got %h expected %h", a, dut_mem[a], mdl_mem[a]);
            end
        end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        clr_pulse      = 1'b0;
        rst            = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        bus.clr_start  = 1'b0;
        for (int a = 0; a < NREG; a++) begin
            mdl_mem[a] = '0;
            dut_mem[a] = '0;
        end
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_x0();
        test_clear_request();
        test_reset_mid_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
